// File: rtl/reg_dest_scoreboard.sv
// Register-destination select with an in-order pending-write queue.
// Exposes a pending-register mask and source-operand stall flags to control.
module reg_dest_scoreboard #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned LINK_A   = 31,
  parameter int unsigned LINK_B   = 29,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          regDest,
  input  logic [ADDR_W-1:0]   rt,
  input  logic [ADDR_W-1:0]   rd,
  input  logic                issue,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   src_a,
  input  logic [ADDR_W-1:0]   src_b,
  output logic [ADDR_W-1:0]   dest_addr,
  output logic                dest_valid,
  output logic [ADDR_W-1:0]   wb_addr,
  output logic [NUM_REGS-1:0] pend_mask,
  output logic                stall_a,
  output logic                stall_b,
  output logic                issue_ready,
  output logic                full,
  output logic                empty,
  output logic                wb_underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [PTR_W:0]    count_q;
  logic [ADDR_W-1:0] dest_addr_q;
  logic              dest_valid_q;
  logic              wb_underflow_q;

  logic [ADDR_W-1:0] sel;
  logic              accept, push, pop;

  always_comb begin
    sel = rt;
    unique case (regDest)
      2'b00: sel = rt;
      2'b01: sel = rd;
      2'b10: sel = ADDR_W'(LINK_A);
      2'b11: sel = ADDR_W'(LINK_B);
    endcase
  end

  assign full        = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign issue_ready = !full || wb_valid;
  assign accept      = issue && issue_ready;
  // $zero is never a real write target, so it is not tracked.
  assign push        = accept && (sel != '0);
  assign pop         = wb_valid && !empty;

  assign wb_addr = empty ? '0 : mem_q[head_q];

  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i < 32'(count_q)) begin
        pend_mask[mem_q[head_q + PTR_W'(i)]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

  // No bypass: a pop this cycle still stalls until the entry is gone.
  assign stall_a = pend_mask[src_a];
  assign stall_b = pend_mask[src_b];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      dest_addr_q    <= '0;
      dest_valid_q   <= 1'b0;
      wb_underflow_q <= 1'b0;
    end else begin
      dest_valid_q <= accept;
      if (accept) begin
        dest_addr_q <= sel;
      end
      if (push) begin
        mem_q[tail_q] <= sel;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      if (wb_valid && empty) begin
        wb_underflow_q <= 1'b1;
      end
    end
  end

  assign dest_addr    = dest_addr_q;
  assign dest_valid   = dest_valid_q;
  assign wb_underflow = wb_underflow_q;

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Directed bench for reg_dest_scoreboard with hand-computed expectations.
module tb_reg_dest_scoreboard;

  logic        clk;
  logic        reset;
  logic [1:0]  regDest;
  logic [4:0]  rt, rd, src_a, src_b;
  logic        issue, wb_valid;
  logic [4:0]  dest_addr, wb_addr;
  logic        dest_valid, stall_a, stall_b, issue_ready, full, empty, wb_underflow;
  logic [31:0] pend_mask;

  int vec_cnt = 0;
  int err_cnt = 0;

  reg_dest_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .regDest      (regDest),
    .rt           (rt),
    .rd           (rd),
    .issue        (issue),
    .wb_valid     (wb_valid),
    .src_a        (src_a),
    .src_b        (src_b),
    .dest_addr    (dest_addr),
    .dest_valid   (dest_valid),
    .wb_addr      (wb_addr),
    .pend_mask    (pend_mask),
    .stall_a      (stall_a),
    .stall_b      (stall_b),
    .issue_ready  (issue_ready),
    .full         (full),
    .empty        (empty),
    .wb_underflow (wb_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [1:0] rsel, input logic [4:0] t, input logic [4:0] d);
    regDest = rsel;
    rt      = t;
    rd      = d;
    issue   = 1'b1;
    step();
    issue   = 1'b0;
  endtask

  task automatic do_pop();
    wb_valid = 1'b1;
    step();
    wb_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    regDest  = 2'b00;
    rt       = '0;
    rd       = '0;
    issue    = 1'b0;
    wb_valid = 1'b0;
    src_a    = '0;
    src_b    = '0;
    #3;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_dest", 32'(dest_addr), 32'd0);
    check("rst_dvalid", 32'(dest_valid), 32'd0);
    check("rst_mask", pend_mask, 32'd0);
    check("rst_uflow", 32'(wb_underflow), 32'd0);
    check("rst_wbaddr", 32'(wb_addr), 32'd0);
    step();
    reset = 1'b1;

    // Single rd issue
    do_issue(2'b01, 5'd0, 5'd8);
    src_a = 5'd8;
    #1;
    check("t1_dest", 32'(dest_addr), 32'd8);
    check("t1_dvalid", 32'(dest_valid), 32'd1);
    check("t1_mask", pend_mask, 32'h0000_0100);
    check("t1_wbaddr", 32'(wb_addr), 32'd8);
    check("t1_stall_a", 32'(stall_a), 32'd1);
    step();
    check("t1_dvalid_pulse", 32'(dest_valid), 32'd0);
    do_pop();
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_stall_a_clr", 32'(stall_a), 32'd0);

    // Fill to DEPTH with every select code
    do_issue(2'b00, 5'd5, 5'd0);
    do_issue(2'b10, 5'd0, 5'd0);
    do_issue(2'b11, 5'd0, 5'd0);
    do_issue(2'b01, 5'd0, 5'd9);
    src_b = 5'd9;
    #1;
    check("t2_full", 32'(full), 32'd1);
    check("t2_mask", pend_mask, 32'hA000_0220);
    check("t2_ready", 32'(issue_ready), 32'd0);
    check("t2_stall_b", 32'(stall_b), 32'd1);
    check("t2_wbaddr", 32'(wb_addr), 32'd5);
    regDest = 2'b01;
    rd      = 5'd12;
    issue   = 1'b1;
    step();
    check("t2_refused_dest", 32'(dest_addr), 32'd9);
    check("t2_refused_dv", 32'(dest_valid), 32'd0);
    check("t2_refused_full", 32'(full), 32'd1);
    wb_valid = 1'b1;
    #1;
    check("t2_ready_wb", 32'(issue_ready), 32'd1);
    step();
    issue    = 1'b0;
    wb_valid = 1'b0;
    check("t2_acc_full", 32'(full), 32'd1);
    check("t2_acc_wbaddr", 32'(wb_addr), 32'd31);
    check("t2_acc_dest", 32'(dest_addr), 32'd12);
    check("t2_acc_dv", 32'(dest_valid), 32'd1);
    check("t2_acc_mask", pend_mask, 32'hA000_1200);
    do_pop();
    check("t2_pop1", 32'(wb_addr), 32'd29);
    do_pop();
    check("t2_pop2", 32'(wb_addr), 32'd9);
    do_pop();
    check("t2_pop3", 32'(wb_addr), 32'd12);
    do_pop();
    check("t2_pop4", 32'(wb_addr), 32'd0);
    check("t2_drained", 32'(empty), 32'd1);
    check("t2_mask0", pend_mask, 32'd0);

    // Duplicate targets
    do_issue(2'b01, 5'd0, 5'd7);
    do_issue(2'b01, 5'd0, 5'd7);
    do_pop();
    src_b = 5'd7;
    #1;
    check("t3_dup_mask", pend_mask, 32'h0000_0080);
    check("t3_dup_wbaddr", 32'(wb_addr), 32'd7);
    wb_valid = 1'b1;
    #1;
    check("t3_nobypass", 32'(stall_b), 32'd1);
    step();
    wb_valid = 1'b0;
    check("t3_mask_clr", pend_mask, 32'd0);
    check("t3_stall_clr", 32'(stall_b), 32'd0);
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_wbaddr0", 32'(wb_addr), 32'd0);

    // $zero destination
    do_issue(2'b00, 5'd0, 5'd0);
    check("t4_dv", 32'(dest_valid), 32'd1);
    check("t4_dest", 32'(dest_addr), 32'd0);
    check("t4_empty", 32'(empty), 32'd1);
    check("t4_mask", pend_mask, 32'd0);

    // Underflow
    do_pop();
    check("t5_uflow", 32'(wb_underflow), 32'd1);
    check("t5_empty", 32'(empty), 32'd1);
    step();
    check("t5_sticky", 32'(wb_underflow), 32'd1);
    do_issue(2'b01, 5'd0, 5'd3);
    check("t5_wbaddr", 32'(wb_addr), 32'd3);
    do_pop();
    check("t5_after_empty", 32'(empty), 32'd1);
    check("t5_still_sticky", 32'(wb_underflow), 32'd1);

    // Asynchronous reset mid-operation
    do_issue(2'b01, 5'd0, 5'd10);
    do_issue(2'b01, 5'd0, 5'd11);
    do_issue(2'b01, 5'd0, 5'd12);
    #2;
    reset = 1'b0;
    #1;
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_mask", pend_mask, 32'd0);
    check("t6_dest", 32'(dest_addr), 32'd0);
    check("t6_dv", 32'(dest_valid), 32'd0);
    check("t6_uflow", 32'(wb_underflow), 32'd0);
    check("t6_wbaddr", 32'(wb_addr), 32'd0);
    step();
    reset = 1'b1;

    // Pointer wrap-around with simultaneous push and pop
    do_issue(2'b01, 5'd0, 5'd20);
    do_issue(2'b01, 5'd0, 5'd21);
    for (int k = 0; k < 6; k++) begin
      wb_valid = 1'b1;
      do_issue(2'b01, 5'd0, 5'(22 + k));
      wb_valid = 1'b0;
      check("t6_wrap_wbaddr", 32'(wb_addr), 32'(21 + k));
      check("t6_wrap_mask", pend_mask, (32'h1 << (21 + k)) | (32'h1 << (22 + k)));
    end
    do_pop();
    check("t6_tail1", 32'(wb_addr), 32'd27);
    do_pop();
    check("t6_tail2", 32'(wb_addr), 32'd0);
    check("t6_final_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
